// File: rtl/scaler_ddr_packer.sv
// scaler_ddr_packer: converts the scaler's RGB888 de/pixel stream to RGB565,
// packs PPW pixels per output word, tags each word with its frame-buffer byte
// address and queues it in a small show-ahead FIFO for the DDR write master.
//
// Output handshake: o_valid/o_data/o_addr come straight from registers; a word
// is transferred on any cycle where o_valid & i_ready are both high. While
// o_valid is high and i_ready is low, o_data/o_addr are held stable. After a
// transfer, the next queued word appears on the following cycle with no bubble.
module scaler_ddr_packer #(
  parameter int PIXEL_DATA_WIDTH     = 24,
  parameter int DST_IMAGE_RES_WIDTH  = 320,
  parameter int DST_IMAGE_RES_HEIGHT = 360,
  parameter int OUT_DATA_WIDTH       = 128,
  parameter int FIFO_DEPTH           = 16,
  parameter int ADDR_WIDTH           = 28,
  parameter int BASE_ADDR            = 0
) (
  input  logic                        pixclk_in,
  input  logic                        rst_n,
  input  logic                        vs_in,
  input  logic                        de_in,
  input  logic [PIXEL_DATA_WIDTH-1:0] i_pixel,
  output logic [OUT_DATA_WIDTH-1:0]   o_data,
  output logic [ADDR_WIDTH-1:0]       o_addr,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic                        o_frame_done,
  output logic                        o_overflow,
  output logic                        o_line_err,
  output logic [15:0]                 o_line_cnt
);

  localparam int PPW     = OUT_DATA_WIDTH / 16;
  localparam int LANE_W  = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int BPW     = OUT_DATA_WIDTH / 8;
  localparam int STRIDE  = DST_IMAGE_RES_WIDTH * 2;
  localparam int ENTRY_W = 1 + ADDR_WIDTH + OUT_DATA_WIDTH;

  // Input-side position tracking and the word being assembled
  logic                      r_de_d;
  logic [15:0]               r_pix_idx;
  logic [LANE_W-1:0]         r_lane;
  logic [OUT_DATA_WIDTH-1:0] r_pack;
  logic [15:0]               r_word_idx;
  logic [15:0]               r_line;
  logic [ADDR_WIDTH-1:0]     r_line_addr;
  logic                      r_line_err;

  // Completed word waiting one cycle to be pushed into the FIFO
  logic                      r_wr_valid;
  logic [OUT_DATA_WIDTH-1:0] r_wr_data;
  logic [ADDR_WIDTH-1:0]     r_wr_addr;
  logic                      r_wr_last;

  // FIFO storage, pointers and registered head
  logic [ENTRY_W-1:0]        r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]          r_wr_ptr;
  logic [PTR_W-1:0]          r_rd_ptr;
  logic [PTR_W:0]            r_count;
  logic                      r_out_valid;
  logic [ENTRY_W-1:0]        r_out;
  logic                      r_overflow;

  logic [15:0]               w_pix565;
  logic [OUT_DATA_WIDTH-1:0] w_pack_ins;
  logic                      w_de_fall;
  logic                      w_active;
  logic [ADDR_WIDTH-1:0]     w_word_addr;
  logic                      w_pop;
  logic                      w_push_ok;
  logic [PTR_W-1:0]          w_rd_next;
  logic [PTR_W:0]            w_remain;
  logic                      w_unused;

  // RGB565 by truncation; the dropped low bits of each channel are unused
  assign w_pix565 = {i_pixel[23:19], i_pixel[15:10], i_pixel[7:3]};
  assign w_unused = ^{i_pixel[18:16], i_pixel[9:8], i_pixel[2:0]};

  assign w_de_fall   = r_de_d & ~de_in;
  assign w_active    = (r_line < 16'(DST_IMAGE_RES_HEIGHT));
  assign w_word_addr = r_line_addr + ADDR_WIDTH'(r_word_idx) * ADDR_WIDTH'(BPW);

  // Current pack register with the incoming pixel dropped into its lane
  always_comb begin
    w_pack_ins = r_pack;
    w_pack_ins[r_lane*16 +: 16] = w_pix565;
  end

  // Pixel intake: lane packing, word completion, line/frame bookkeeping
  always_ff @(posedge pixclk_in) begin
    if (!rst_n) begin
      r_de_d      <= 1'b0;
      r_pix_idx   <= '0;
      r_lane      <= '0;
      r_pack      <= '0;
      r_word_idx  <= '0;
      r_line      <= '0;
      r_line_addr <= ADDR_WIDTH'(BASE_ADDR);
      r_line_err  <= 1'b0;
      r_wr_valid  <= 1'b0;
      r_wr_data   <= '0;
      r_wr_addr   <= '0;
      r_wr_last   <= 1'b0;
    end else begin
      r_de_d     <= de_in;
      r_wr_valid <= 1'b0;
      if (vs_in) begin
        // Frame start wins over any pixel presented in the same cycle
        r_pix_idx   <= '0;
        r_lane      <= '0;
        r_pack      <= '0;
        r_word_idx  <= '0;
        r_line      <= '0;
        r_line_addr <= ADDR_WIDTH'(BASE_ADDR);
        r_line_err  <= 1'b0;
      end else if (w_active) begin
        if (de_in) begin
          if (r_pix_idx < 16'(DST_IMAGE_RES_WIDTH)) begin
            r_pix_idx <= r_pix_idx + 16'd1;
            if (r_lane == LANE_W'(PPW - 1)) begin
              r_wr_valid <= 1'b1;
              r_wr_data  <= w_pack_ins;
              r_wr_addr  <= w_word_addr;
              r_wr_last  <= (r_line == 16'(DST_IMAGE_RES_HEIGHT - 1)) &&
                            (r_pix_idx == 16'(DST_IMAGE_RES_WIDTH - 1));
              r_pack     <= '0;
              r_lane     <= '0;
              r_word_idx <= r_word_idx + 16'd1;
            end else begin
              r_pack <= w_pack_ins;
              r_lane <= r_lane + LANE_W'(1);
            end
          end else begin
            // Excess pixels in an over-long burst are discarded
            r_line_err <= 1'b1;
          end
        end else if (w_de_fall) begin
          // Flush a partial word; untouched lanes are already zero
          if (r_lane != '0) begin
            r_wr_valid <= 1'b1;
            r_wr_data  <= r_pack;
            r_wr_addr  <= w_word_addr;
            r_wr_last  <= (r_line == 16'(DST_IMAGE_RES_HEIGHT - 1));
          end
          r_pack      <= '0;
          r_lane      <= '0;
          r_pix_idx   <= '0;
          r_word_idx  <= '0;
          r_line      <= r_line + 16'd1;
          r_line_addr <= r_line_addr + ADDR_WIDTH'(STRIDE);
        end
      end
    end
  end

  assign w_pop     = r_out_valid & i_ready;
  assign w_push_ok = r_wr_valid & ((r_count < (PTR_W+1)'(FIFO_DEPTH)) | w_pop);
  assign w_rd_next = r_rd_ptr + PTR_W'(w_pop);
  assign w_remain  = r_count - (PTR_W+1)'(w_pop);

  // FIFO storage write; contents need no reset since r_count gates use
  always_ff @(posedge pixclk_in) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= {r_wr_last, r_wr_addr, r_wr_data};
    end
  end

  // FIFO pointers, registered show-ahead head and sticky overflow flag
  always_ff @(posedge pixclk_in) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      r_rd_ptr    <= w_rd_next;
      r_count     <= r_count + (PTR_W+1)'(w_push_ok) - (PTR_W+1)'(w_pop);
      // Head reflects entries already stored; a word pushed this edge shows next edge
      r_out_valid <= (w_remain != '0);
      if (w_remain != '0) r_out <= r_mem[w_rd_next];
      if (vs_in) r_overflow <= 1'b0;
      else if (r_wr_valid && !w_push_ok) r_overflow <= 1'b1;
    end
  end

  assign o_valid      = r_out_valid;
  assign o_data       = r_out[OUT_DATA_WIDTH-1:0];
  assign o_addr       = r_out[OUT_DATA_WIDTH +: ADDR_WIDTH];
  assign o_frame_done = w_pop & r_out[ENTRY_W-1];
  assign o_overflow   = r_overflow;
  assign o_line_err   = r_line_err;
  assign o_line_cnt   = r_line;

endmodule

// File: tb/tb_scaler_ddr_packer.sv
// Directed bench for scaler_ddr_packer. A short frame height keeps the
// full-frame scenario brief; line width and word size are the defaults.
module tb_scaler_ddr_packer;

  localparam int W  = 320;
  localparam int H  = 8;
  localparam int OW = 128;
  localparam int AW = 28;

  logic          pixclk_in = 1'b0;
  logic          rst_n;
  logic          vs_in;
  logic          de_in;
  logic [23:0]   i_pixel;
  logic [OW-1:0] o_data;
  logic [AW-1:0] o_addr;
  logic          o_valid;
  logic          i_ready;
  logic          o_frame_done;
  logic          o_overflow;
  logic          o_line_err;
  logic [15:0]   o_line_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  // Accepted words, recorded by the monitor below
  logic [AW-1:0] acc_addr_q[$];
  logic [OW-1:0] acc_data_q[$];
  logic          acc_fd_q[$];
  int            fd_cnt = 0;

  // Expected words for the full-frame scenario
  logic [OW-1:0] exp_q[$];
  logic [AW-1:0] exp_addr_q[$];

  // Clock / reset
  always #5 pixclk_in = ~pixclk_in;

  scaler_ddr_packer #(
    .DST_IMAGE_RES_HEIGHT(H)
  ) dut (
    .pixclk_in    (pixclk_in),
    .rst_n        (rst_n),
    .vs_in        (vs_in),
    .de_in        (de_in),
    .i_pixel      (i_pixel),
    .o_data       (o_data),
    .o_addr       (o_addr),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_frame_done (o_frame_done),
    .o_overflow   (o_overflow),
    .o_line_err   (o_line_err),
    .o_line_cnt   (o_line_cnt)
  );

  // Monitor: record each transfer half a cycle before its accepting edge
  always @(negedge pixclk_in) begin
    if (o_valid && i_ready) begin
      acc_addr_q.push_back(o_addr);
      acc_data_q.push_back(o_data);
      acc_fd_q.push_back(o_frame_done);
    end
    if (o_frame_done) fd_cnt++;
  end

  function automatic logic [23:0] pix(int l, int i);
    logic [7:0] a;
    logic [7:0] b;
    a = i[7:0];
    b = 8'h80 ^ l[7:0];
    return {a, b, 8'hFF};
  endfunction

  function automatic logic [15:0] to565(logic [23:0] p);
    return {p[23:19], p[15:10], p[7:3]};
  endfunction

  function automatic logic [OW-1:0] exp_word(int l, int w, int npix);
    logic [OW-1:0] d;
    d = '0;
    for (int k = 0; k < 8; k++) begin
      if (w * 8 + k < npix) d[k*16 +: 16] = to565(pix(l, w * 8 + k));
    end
    return d;
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge pixclk_in);
    #1;
  endtask

  task automatic send_vs();
    vs_in = 1'b1;
    tick();
    vs_in = 1'b0;
    tick();
  endtask

  task automatic send_line(input int n, input int l, input bit rnd);
    for (int i = 0; i < n; i++) begin
      de_in   = 1'b1;
      i_pixel = pix(l, i);
      if (rnd) i_ready = 1'($urandom_range(0, 1));
      tick();
    end
    de_in   = 1'b0;
    i_pixel = '0;
    tick();
    tick();
  endtask

  task automatic wait_words(input int target, input bit rnd);
    for (int c = 0; c < 4000 && acc_addr_q.size() < target; c++) begin
      if (rnd) i_ready = 1'($urandom_range(0, 1));
      tick();
    end
    i_ready = 1'b1;
    repeat (20) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; vs_in = 1'b0; de_in = 1'b0; i_pixel = '0; i_ready = 1'b0;
    repeat (3) tick();
    tests_run++;
    if ({o_valid, o_frame_done, o_overflow, o_line_err} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b expected 0000", {o_valid, o_frame_done, o_overflow, o_line_err});
    end
    tests_run++;
    if (o_data !== '0 || o_addr !== '0 || o_line_cnt !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_values: got data %h addr %h line %0d expected all zero", o_data, o_addr, o_line_cnt);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_full_line();
    int base;
    logic [OW-1:0] d;
    i_ready = 1'b1;
    send_vs();
    base = acc_addr_q.size();
    for (int i = 0; i < W; i++) begin
      de_in   = 1'b1;
      i_pixel = pix(0, i);
      tick();
      if (i == 8) begin
        tests_run++;
        if (o_valid !== 1'b0) begin
          tests_failed++;
          $display("FAIL latency_early: o_valid got %b expected 0 one edge after 8th pixel", o_valid);
        end
      end
      if (i == 9) begin
        tests_run++;
        if (o_valid !== 1'b1) begin
          tests_failed++;
          $display("FAIL latency_first: o_valid got %b expected 1 two edges after 8th pixel", o_valid);
        end
      end
    end
    de_in = 1'b0;
    tick();
    tick();
    wait_words(base + 40, 1'b0);
    tests_run++;
    if (acc_addr_q.size() != base + 40) begin
      tests_failed++;
      $display("FAIL line_word_count: got %0d expected 40", acc_addr_q.size() - base);
    end else begin
      for (int w = 0; w < 40; w++) begin
        tests_run++;
        if (acc_addr_q[base+w] !== AW'(w * 16) || acc_data_q[base+w] !== exp_word(0, w, W)) begin
          tests_failed++;
          $display("FAIL line_word_%0d: got addr %h data %h expected addr %h data %h",
                   w, acc_addr_q[base+w], acc_data_q[base+w], AW'(w * 16), exp_word(0, w, W));
        end
      end
      d = acc_data_q[base];
      tests_run++;
      if (d !== {8{16'h041F}}) begin
        tests_failed++;
        $display("FAIL line_word0_lanes: got %h expected %h", d, {8{16'h041F}});
      end
      d = acc_data_q[base+39];
      tests_run++;
      if (d[127:112] !== 16'h3C1F || acc_addr_q[base+39] !== 28'd624) begin
        tests_failed++;
        $display("FAIL line_last_word: got lane7 %h addr %0d expected 3c1f addr 624", d[127:112], acc_addr_q[base+39]);
      end
    end
    tests_run++;
    if (o_line_cnt !== 16'd1) begin
      tests_failed++;
      $display("FAIL line_cnt_after_line: got %0d expected 1", o_line_cnt);
    end
  endtask

  task automatic test_partial_line();
    int base;
    i_ready = 1'b1;
    send_vs();
    base = acc_addr_q.size();
    send_line(12, 0, 1'b0);
    send_line(8, 0, 1'b0);
    wait_words(base + 3, 1'b0);
    tests_run++;
    if (acc_addr_q.size() != base + 3) begin
      tests_failed++;
      $display("FAIL partial_word_count: got %0d expected 3", acc_addr_q.size() - base);
    end else begin
      tests_run++;
      if (acc_addr_q[base] !== 28'd0 || acc_addr_q[base+1] !== 28'd16 || acc_addr_q[base+2] !== 28'd640) begin
        tests_failed++;
        $display("FAIL partial_addrs: got %0d %0d %0d expected 0 16 640",
                 acc_addr_q[base], acc_addr_q[base+1], acc_addr_q[base+2]);
      end
      tests_run++;
      if (acc_data_q[base+1] !== {64'h0, {4{16'h0C1F}}}) begin
        tests_failed++;
        $display("FAIL partial_zero_lanes: got %h expected %h", acc_data_q[base+1], {64'h0, {4{16'h0C1F}}});
      end
      tests_run++;
      if (acc_data_q[base+2] !== {8{16'h041F}}) begin
        tests_failed++;
        $display("FAIL partial_next_line: got %h expected %h", acc_data_q[base+2], {8{16'h041F}});
      end
    end
  endtask

  task automatic test_overflow();
    int base;
    i_ready = 1'b0;
    send_vs();
    base = acc_addr_q.size();
    for (int l = 0; l < 3; l++) send_line(W, 0, 1'b0);
    tests_run++;
    if (o_overflow !== 1'b1 || o_valid !== 1'b1 || o_line_cnt !== 16'd3) begin
      tests_failed++;
      $display("FAIL ovf_flags: got ovf %b valid %b line %0d expected 1 1 3", o_overflow, o_valid, o_line_cnt);
    end
    for (int s = 0; s < 4; s++) begin
      tick();
      tests_run++;
      if (o_addr !== 28'd0 || o_data !== exp_word(0, 0, W)) begin
        tests_failed++;
        $display("FAIL ovf_stall_hold: got addr %h data %h expected addr 0 data %h", o_addr, o_data, exp_word(0, 0, W));
      end
    end
    i_ready = 1'b1;
    wait_words(base + 16, 1'b0);
    tests_run++;
    if (acc_addr_q.size() != base + 16) begin
      tests_failed++;
      $display("FAIL ovf_drain_count: got %0d expected 16", acc_addr_q.size() - base);
    end else begin
      for (int w = 0; w < 16; w++) begin
        tests_run++;
        if (acc_addr_q[base+w] !== AW'(w * 16) || acc_data_q[base+w] !== exp_word(0, w, W)) begin
          tests_failed++;
          $display("FAIL ovf_drain_%0d: got addr %h data %h expected addr %h data %h",
                   w, acc_addr_q[base+w], acc_data_q[base+w], AW'(w * 16), exp_word(0, w, W));
        end
      end
    end
    send_vs();
    tests_run++;
    if (o_overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovf_clear: got %b expected 0", o_overflow);
    end
  endtask

  task automatic test_frame();
    int base;
    int fd0;
    logic [AW-1:0] a;
    i_ready = 1'b1;
    send_vs();
    base = acc_addr_q.size();
    fd0  = fd_cnt;
    exp_q.delete();
    exp_addr_q.delete();
    for (int l = 0; l < H; l++) begin
      send_line(W, l, 1'b1);
      for (int w = 0; w < 40; w++) begin
        exp_q.push_back(exp_word(l, w, W));
        exp_addr_q.push_back(AW'(l * 640 + w * 16));
      end
    end
    send_line(W, 9, 1'b1);
    wait_words(base + H * 40, 1'b1);
    tests_run++;
    if (acc_addr_q.size() != base + H * 40) begin
      tests_failed++;
      $display("FAIL frame_word_count: got %0d expected %0d", acc_addr_q.size() - base, H * 40);
    end else begin
      for (int j = 0; j < H * 40; j++) begin
        tests_run++;
        if (acc_addr_q[base+j] !== exp_addr_q[j] || acc_data_q[base+j] !== exp_q[j]) begin
          tests_failed++;
          $display("FAIL frame_word_%0d: got addr %h data %h expected addr %h data %h",
                   j, acc_addr_q[base+j], acc_data_q[base+j], exp_addr_q[j], exp_q[j]);
        end
      end
      a = acc_addr_q[base+H*40-1];
      tests_run++;
      if (a !== 28'd5104 || acc_fd_q[base+H*40-1] !== 1'b1) begin
        tests_failed++;
        $display("FAIL frame_last_word: got addr %0d done %b expected addr 5104 done 1", a, acc_fd_q[base+H*40-1]);
      end
    end
    tests_run++;
    if (fd_cnt - fd0 != 1) begin
      tests_failed++;
      $display("FAIL frame_done_count: got %0d expected 1", fd_cnt - fd0);
    end
    tests_run++;
    if (o_line_cnt !== 16'(H)) begin
      tests_failed++;
      $display("FAIL frame_line_hold: got %0d expected %0d", o_line_cnt, H);
    end
  endtask

  task automatic test_long_line_and_vs();
    int base;
    int base2;
    i_ready = 1'b1;
    send_vs();
    base = acc_addr_q.size();
    send_line(330, 0, 1'b0);
    wait_words(base + 40, 1'b0);
    tests_run++;
    if (acc_addr_q.size() != base + 40) begin
      tests_failed++;
      $display("FAIL long_word_count: got %0d expected 40", acc_addr_q.size() - base);
    end else begin
      tests_run++;
      if (acc_addr_q[base+39] !== 28'd624 || acc_data_q[base+39] !== exp_word(0, 39, W)) begin
        tests_failed++;
        $display("FAIL long_last_word: got addr %h data %h expected addr 270 data %h",
                 acc_addr_q[base+39], acc_data_q[base+39], exp_word(0, 39, W));
      end
    end
    tests_run++;
    if (o_line_err !== 1'b1 || o_line_cnt !== 16'd1) begin
      tests_failed++;
      $display("FAIL long_line_err: got err %b line %0d expected 1 1", o_line_err, o_line_cnt);
    end
    base2   = acc_addr_q.size();
    vs_in   = 1'b1;
    de_in   = 1'b1;
    i_pixel = 24'hFFFFFF;
    tick();
    vs_in = 1'b0;
    tests_run++;
    if (o_line_err !== 1'b0 || o_line_cnt !== 16'd0) begin
      tests_failed++;
      $display("FAIL vs_de_clear: got err %b line %0d expected 0 0", o_line_err, o_line_cnt);
    end
    for (int i = 0; i < 8; i++) begin
      i_pixel = pix(0, i);
      tick();
    end
    de_in = 1'b0;
    tick();
    tick();
    wait_words(base2 + 1, 1'b0);
    tests_run++;
    if (acc_addr_q.size() != base2 + 1) begin
      tests_failed++;
      $display("FAIL vs_de_word_count: got %0d expected 1", acc_addr_q.size() - base2);
    end else begin
      tests_run++;
      if (acc_addr_q[base2] !== 28'd0 || acc_data_q[base2] !== {8{16'h041F}}) begin
        tests_failed++;
        $display("FAIL vs_de_word: got addr %h data %h expected addr 0 data %h",
                 acc_addr_q[base2], acc_data_q[base2], {8{16'h041F}});
      end
    end
  endtask

  task automatic test_mid_reset();
    int base;
    i_ready = 1'b1;
    send_vs();
    i_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      de_in   = 1'b1;
      i_pixel = pix(0, i);
      tick();
    end
    tests_run++;
    if (o_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_pre_valid: got %b expected 1", o_valid);
    end
    rst_n = 1'b0;
    tick();
    tests_run++;
    if (o_valid !== 1'b0 || o_line_cnt !== 16'd0) begin
      tests_failed++;
      $display("FAIL rst_mid: got valid %b line %0d expected 0 0", o_valid, o_line_cnt);
    end
    rst_n   = 1'b1;
    de_in   = 1'b0;
    i_ready = 1'b1;
    tick();
    base = acc_addr_q.size();
    send_line(8, 0, 1'b0);
    wait_words(base + 1, 1'b0);
    tests_run++;
    if (acc_addr_q.size() != base + 1) begin
      tests_failed++;
      $display("FAIL rst_word_count: got %0d expected 1", acc_addr_q.size() - base);
    end else begin
      tests_run++;
      if (acc_addr_q[base] !== 28'd0 || acc_data_q[base] !== {8{16'h041F}}) begin
        tests_failed++;
        $display("FAIL rst_restart_word: got addr %h data %h expected addr 0 data %h",
                 acc_addr_q[base], acc_data_q[base], {8{16'h041F}});
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_line();
    test_partial_line();
    test_overflow();
    test_frame();
    test_long_line_and_vs();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
